// File: rtl/banked_regfile.sv
// Register file with a shadow bank for the upper indices, swapped in while an
// interrupt is being serviced, plus one unbanked index mapped to an IO port.
module banked_regfile #(
  parameter int WIDTH     = 8,
  parameter int NREGS     = 4,
  parameter int BANK_BASE = 2,
  parameter int IO_IDX    = 1,
  localparam int S        = $clog2(NREGS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [S-1:0]       wr_sel,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [S-1:0]       rd_sel_a,
  input  logic [S-1:0]       rd_sel_b,
  output logic [WIDTH-1:0]   rd_a,
  output logic [WIDTH-1:0]   rd_b,
  input  logic               int_req,
  input  logic               ienabled,
  input  logic               int_ret,
  input  logic [2*WIDTH-1:0] ret_addr,
  output logic               int_ack,
  output logic               in_int,
  input  logic [WIDTH-1:0]   io_in,
  output logic [WIDTH-1:0]   io_out,
  output logic               ior,
  output logic               iow
);

  localparam int NSHAD = NREGS - BANK_BASE;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    ACTIVE = 2'd2,
    EXIT   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q   [NREGS];
  logic [WIDTH-1:0] main_d   [NREGS];
  logic [WIDTH-1:0] shadow_q [NSHAD];
  logic [WIDTH-1:0] shadow_d [NSHAD];
  logic [WIDTH-1:0] io_out_q, io_out_d;
  logic             iow_q, iow_d;
  logic             wr_io;
  logic [WIDTH-1:0] rd_a_store, rd_b_store;

  assign in_int  = (state_q == ACTIVE) || (state_q == EXIT);
  assign int_ack = (state_q == ENTRY);
  assign wr_io   = wr_en && (wr_sel == S'(IO_IDX));
  assign io_out  = io_out_q;
  assign iow     = iow_q;
  assign ior     = (rd_sel_a == S'(IO_IDX));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (int_req && ienabled) state_d = ENTRY;
      ENTRY:   state_d = ACTIVE;
      ACTIVE:  if (int_ret) state_d = EXIT;
      EXIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bank steering follows in_int, so ENTRY writes land in main and EXIT writes in shadow.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      main_d[i] = main_q[i];
      if (wr_en && (wr_sel == S'(i)) && !(in_int && (i >= BANK_BASE)))
        main_d[i] = wr_data;
    end
    for (int i = 0; i < NSHAD; i++) begin
      shadow_d[i] = shadow_q[i];
      if (wr_en && in_int && (wr_sel == S'(i + BANK_BASE)))
        shadow_d[i] = wr_data;
    end
    if (state_q == ENTRY) begin
      shadow_d[0] = ret_addr[WIDTH-1:0];
      shadow_d[1] = ret_addr[2*WIDTH-1:WIDTH];
    end
    io_out_d = wr_io ? wr_data : io_out_q;
    iow_d    = wr_io;
  end

  always_comb begin
    rd_a_store = '0;
    rd_b_store = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_sel_a == S'(i)) rd_a_store = main_q[i];
      if (rd_sel_b == S'(i)) rd_b_store = main_q[i];
    end
    for (int i = 0; i < NSHAD; i++) begin
      if (in_int && (rd_sel_a == S'(i + BANK_BASE))) rd_a_store = shadow_q[i];
      if (in_int && (rd_sel_b == S'(i + BANK_BASE))) rd_b_store = shadow_q[i];
    end
  end

  // Port A sees the live external input at the IO index; port B sees the stored copy.
  assign rd_a = ior ? io_in : rd_a_store;
  assign rd_b = rd_b_store;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      io_out_q <= '0;
      iow_q    <= 1'b0;
      for (int i = 0; i < NREGS; i++) main_q[i] <= '0;
      for (int i = 0; i < NSHAD; i++) shadow_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      io_out_q <= io_out_d;
      iow_q    <= iow_d;
      main_q   <= main_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: tb/tb_banked_regfile.sv
// Directed bench for banked_regfile: inputs change on the falling edge and
// outputs are checked 1ns later, well away from the rising edge.
module tb_banked_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [7:0]  wr_data;
  logic [1:0]  rd_sel_a, rd_sel_b;
  logic [7:0]  rd_a, rd_b;
  logic        int_req, ienabled, int_ret;
  logic [15:0] ret_addr;
  logic        int_ack, in_int;
  logic [7:0]  io_in, io_out;
  logic        ior, iow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  banked_regfile #(.WIDTH(8), .NREGS(4), .BANK_BASE(2), .IO_IDX(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_sel_a(rd_sel_a), .rd_sel_b(rd_sel_b), .rd_a(rd_a), .rd_b(rd_b),
    .int_req(int_req), .ienabled(ienabled), .int_ret(int_ret), .ret_addr(ret_addr),
    .int_ack(int_ack), .in_int(in_int), .io_in(io_in), .io_out(io_out),
    .ior(ior), .iow(iow)
  );

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_sel = '0; wr_data = '0; rd_sel_a = '0; rd_sel_b = '0;
    int_req = 1'b0; ienabled = 1'b0; int_ret = 1'b0; ret_addr = '0; io_in = 8'hA5;
    next_cycle(); next_cycle();
    rst = 1'b0;
    #1;
    checks++; if (in_int !== 1'b0) begin errors++; $display("FAIL reset_in_int: got %b expected 0", in_int); end
    checks++; if (int_ack !== 1'b0) begin errors++; $display("FAIL reset_int_ack: got %b expected 0", int_ack); end
    checks++; if (iow !== 1'b0) begin errors++; $display("FAIL reset_iow: got %b expected 0", iow); end
    checks++; if (io_out !== 8'h00) begin errors++; $display("FAIL reset_io_out: got %h expected 00", io_out); end
    for (int i = 0; i < 4; i++) begin
      rd_sel_b = 2'(i);
      rd_sel_a = (i == 1) ? 2'd0 : 2'(i);
      #1;
      checks++; if (rd_b !== 8'h00) begin errors++; $display("FAIL reset_rd_b[%0d]: got %h expected 00", i, rd_b); end
      checks++; if (rd_a !== 8'h00) begin errors++; $display("FAIL reset_rd_a[%0d]: got %h expected 00", i, rd_a); end
    end
    $display("test_reset: done");
  endtask

  task automatic test_write_read();
    next_cycle();
    wr_en = 1'b1; wr_sel = 2'd3; wr_data = 8'h5A; rd_sel_a = 2'd3; rd_sel_b = 2'd3;
    #1;
    checks++; if (rd_a !== 8'h00) begin errors++; $display("FAIL wr_same_cycle_a: got %h expected 00", rd_a); end
    checks++; if (rd_b !== 8'h00) begin errors++; $display("FAIL wr_same_cycle_b: got %h expected 00", rd_b); end
    $display("write idx3 <= 5A");
    next_cycle();
    wr_sel = 2'd2; wr_data = 8'h33;
    #1;
    checks++; if (rd_a !== 8'h5A) begin errors++; $display("FAIL wr_rd_a: got %h expected 5A", rd_a); end
    checks++; if (rd_b !== 8'h5A) begin errors++; $display("FAIL wr_rd_b: got %h expected 5A", rd_b); end
    $display("write idx2 <= 33");
    next_cycle();
    wr_sel = 2'd0; wr_data = 8'h99;
    $display("write idx0 <= 99");
    next_cycle();
    wr_en = 1'b0; rd_sel_a = 2'd0; rd_sel_b = 2'd2;
    #1;
    checks++; if (rd_a !== 8'h99) begin errors++; $display("FAIL rd_idx0: got %h expected 99", rd_a); end
    checks++; if (rd_b !== 8'h33) begin errors++; $display("FAIL rd_idx2: got %h expected 33", rd_b); end
  endtask

  task automatic test_interrupt_entry();
    next_cycle();
    int_req = 1'b1; ienabled = 1'b1; ret_addr = 16'hBEEF;
    #1;
    checks++; if (int_ack !== 1'b0) begin errors++; $display("FAIL entry_early_ack: got %b expected 0", int_ack); end
    next_cycle();
    int_req = 1'b0;
    wr_en = 1'b1; wr_sel = 2'd2; wr_data = 8'h66; rd_sel_a = 2'd2; rd_sel_b = 2'd3;
    #1;
    checks++; if (int_ack !== 1'b1) begin errors++; $display("FAIL entry_ack: got %b expected 1", int_ack); end
    checks++; if (in_int !== 1'b0) begin errors++; $display("FAIL entry_in_int: got %b expected 0", in_int); end
    checks++; if (rd_a !== 8'h33) begin errors++; $display("FAIL entry_rd_main2: got %h expected 33", rd_a); end
    $display("entry: write idx2 <= 66 (main)");
    next_cycle();
    wr_en = 1'b0;
    #1;
    checks++; if (int_ack !== 1'b0) begin errors++; $display("FAIL active_ack: got %b expected 0", int_ack); end
    checks++; if (in_int !== 1'b1) begin errors++; $display("FAIL active_in_int: got %b expected 1", in_int); end
    checks++; if (rd_a !== 8'hEF) begin errors++; $display("FAIL shadow2: got %h expected EF", rd_a); end
    checks++; if (rd_b !== 8'hBE) begin errors++; $display("FAIL shadow3: got %h expected BE", rd_b); end
    rd_sel_a = 2'd0;
    #1;
    checks++; if (rd_a !== 8'h99) begin errors++; $display("FAIL active_unbanked0: got %h expected 99", rd_a); end
  endtask

  task automatic test_bank_isolation();
    wr_en = 1'b1; wr_sel = 2'd3; wr_data = 8'h11; rd_sel_a = 2'd3; rd_sel_b = 2'd2;
    $display("active: write idx3 <= 11 (shadow)");
    next_cycle();
    wr_en = 1'b0; int_ret = 1'b1;
    #1;
    checks++; if (rd_a !== 8'h11) begin errors++; $display("FAIL shadow_wr3: got %h expected 11", rd_a); end
    next_cycle();
    int_ret = 1'b0;
    wr_en = 1'b1; wr_sel = 2'd3; wr_data = 8'h22;
    #1;
    checks++; if (in_int !== 1'b1) begin errors++; $display("FAIL exit_in_int: got %b expected 1", in_int); end
    $display("exit: write idx3 <= 22 (shadow)");
    next_cycle();
    wr_en = 1'b0;
    #1;
    checks++; if (in_int !== 1'b0) begin errors++; $display("FAIL idle_in_int: got %b expected 0", in_int); end
    checks++; if (rd_a !== 8'h5A) begin errors++; $display("FAIL main3_restored: got %h expected 5A", rd_a); end
    checks++; if (rd_b !== 8'h66) begin errors++; $display("FAIL main2_entry_write: got %h expected 66", rd_b); end
  endtask

  task automatic test_gating();
    ienabled = 1'b0; int_req = 1'b1; ret_addr = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      #1;
      checks++; if (int_ack !== 1'b0 || in_int !== 1'b0) begin
        errors++; $display("FAIL gated[%0d]: got ack=%b in_int=%b expected 0/0", i, int_ack, in_int);
      end
    end
    ienabled = 1'b1;
    next_cycle();
    #1;
    checks++; if (int_ack !== 1'b1) begin errors++; $display("FAIL gate_entry_ack: got %b expected 1", int_ack); end
    rd_sel_a = 2'd2; rd_sel_b = 2'd3;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      #1;
      checks++; if (int_ack !== 1'b0 || in_int !== 1'b1) begin
        errors++; $display("FAIL held_req[%0d]: got ack=%b in_int=%b expected 0/1", i, int_ack, in_int);
      end
    end
    checks++; if (rd_a !== 8'h34 || rd_b !== 8'h12) begin
      errors++; $display("FAIL ret_addr_1234: got %h/%h expected 34/12", rd_a, rd_b);
    end
    int_ret = 1'b1;
    next_cycle();
    int_ret = 1'b0;
    #1;
    checks++; if (int_ack !== 1'b0 || in_int !== 1'b1) begin
      errors++; $display("FAIL gate_exit: got ack=%b in_int=%b expected 0/1", int_ack, in_int);
    end
    next_cycle();
    #1;
    checks++; if (int_ack !== 1'b0 || in_int !== 1'b0) begin
      errors++; $display("FAIL gate_idle: got ack=%b in_int=%b expected 0/0", int_ack, in_int);
    end
    next_cycle();
    int_req = 1'b0;
    #1;
    checks++; if (int_ack !== 1'b1) begin errors++; $display("FAIL reentry_ack: got %b expected 1", int_ack); end
    next_cycle();
    int_ret = 1'b1;
    next_cycle();
    int_ret = 1'b0;
    next_cycle();
    #1;
    checks++; if (in_int !== 1'b0) begin errors++; $display("FAIL reentry_exit: got %b expected 0", in_int); end
  endtask

  task automatic test_io();
    wr_en = 1'b1; wr_sel = 2'd1; wr_data = 8'hC3; rd_sel_a = 2'd0;
    #1;
    checks++; if (iow !== 1'b0) begin errors++; $display("FAIL iow_early: got %b expected 0", iow); end
    checks++; if (ior !== 1'b0) begin errors++; $display("FAIL ior_idle: got %b expected 0", ior); end
    $display("write idx1 <= C3 (io)");
    next_cycle();
    wr_en = 1'b0; rd_sel_a = 2'd1; rd_sel_b = 2'd1; io_in = 8'h7E;
    #1;
    checks++; if (io_out !== 8'hC3) begin errors++; $display("FAIL io_out: got %h expected C3", io_out); end
    checks++; if (iow !== 1'b1) begin errors++; $display("FAIL iow_pulse: got %b expected 1", iow); end
    checks++; if (rd_a !== 8'h7E) begin errors++; $display("FAIL io_rd_a: got %h expected 7E", rd_a); end
    checks++; if (ior !== 1'b1) begin errors++; $display("FAIL ior: got %b expected 1", ior); end
    checks++; if (rd_b !== 8'hC3) begin errors++; $display("FAIL io_rd_b: got %h expected C3", rd_b); end
    next_cycle();
    #1;
    checks++; if (iow !== 1'b0) begin errors++; $display("FAIL iow_one_cycle: got %b expected 0", iow); end
    checks++; if (io_out !== 8'hC3) begin errors++; $display("FAIL io_out_hold: got %h expected C3", io_out); end
  endtask

  task automatic test_reset_mid_interrupt();
    int_req = 1'b1; ienabled = 1'b1; ret_addr = 16'hCAFE;
    next_cycle();
    int_req = 1'b0;
    next_cycle();
    #1;
    checks++; if (in_int !== 1'b1) begin errors++; $display("FAIL pre_rst_active: got %b expected 1", in_int); end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    checks++; if (in_int !== 1'b0) begin errors++; $display("FAIL rst_in_int: got %b expected 0", in_int); end
    checks++; if (io_out !== 8'h00) begin errors++; $display("FAIL rst_io_out: got %h expected 00", io_out); end
    for (int i = 0; i < 4; i++) begin
      rd_sel_b = 2'(i);
      rd_sel_a = (i == 1) ? 2'd0 : 2'(i);
      #1;
      checks++; if (rd_a !== 8'h00 || rd_b !== 8'h00) begin
        errors++; $display("FAIL rst_reads[%0d]: got %h/%h expected 00/00", i, rd_a, rd_b);
      end
    end
    next_cycle();
    #1;
    checks++; if (int_ack !== 1'b0 || in_int !== 1'b0) begin
      errors++; $display("FAIL rst_stays_idle: got ack=%b in_int=%b expected 0/0", int_ack, in_int);
    end
    int_req = 1'b1;
    next_cycle();
    int_req = 1'b0;
    #1;
    checks++; if (int_ack !== 1'b1) begin errors++; $display("FAIL rst_then_entry: got %b expected 1", int_ack); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_interrupt_entry();
    test_bank_isolation();
    test_gating();
    test_io();
    test_reset_mid_interrupt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
